// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, controller state type and sigma helpers.
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_e;
  localparam logic [255:0] H0 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word sliding-window message schedule; w is W[t] for the current round.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         advance,
  input  logic [511:0] block,
  output logic [31:0]  w
);
  logic [31:0] w_q [16];
  logic [31:0] w_new;
  assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
  assign w = w_q[0];
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) w_q[i] <= block[511 - 32*i -: 32];
    end else if (advance) begin
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w_new;
    end
  end
endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequences one SHA-256 block through an external compression datapath
// and forms the updated chaining value.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] chain_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic         comp_load,
  output logic [255:0] comp_init,
  output logic         comp_enable,
  output logic [31:0]  w_i,
  output logic [31:0]  k_i,
  input  logic [255:0] work_state
);
  state_e       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [511:0] block_q;
  logic [255:0] chain_q, digest_q, digest_d, sum;
  logic         done_q, accept, in_round;
  logic [31:0]  w_sched;
  assign accept   = state_q == IDLE && start;
  assign in_round = state_q == ROUND;
  always_comb begin
    state_d = accept ? LOAD : state_q == LOAD ? ROUND : (in_round && t_q == 6'd63) ? FINAL :
              state_q == FINAL ? IDLE : state_q;
    t_d = in_round ? t_q + 6'd1 : 6'd0;
    sum = '0;
    for (int j = 0; j < 8; j++) sum[32*j +: 32] = chain_q[32*j +: 32] + work_state[32*j +: 32];
    digest_d = state_q == FINAL ? sum : digest_q;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      block_q  <= '0;
      chain_q  <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      digest_q <= digest_d;
      done_q   <= state_q == FINAL;
      if (accept) begin
        block_q <= block_in;
        chain_q <= chain_in;
      end
    end
  end
  sha256_msg_sched u_sched (
    .clk    (clk),
    .n_rst  (n_rst),
    .load   (state_q == LOAD),
    .advance(in_round),
    .block  (block_q),
    .w      (w_sched)
  );
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign digest      = digest_q;
  assign comp_load   = state_q == LOAD;
  assign comp_init   = chain_q;
  assign comp_enable = in_round;
  assign w_i         = in_round ? w_sched : 32'h0;
  assign k_i         = in_round ? K[t_q] : 32'h0;
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: scoreboard bench with a behavioural compression datapath attached.
module tb_sha256_round_ctrl;
  logic         clk = 1'b0, n_rst = 1'b0, start = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] chain_in = '0;
  logic         busy, done, comp_load, comp_enable;
  logic [255:0] digest, comp_init, work_state, mon_exp;
  logic [31:0]  w_i, k_i;
  logic [255:0] exp_q [$];
  int           checks = 0, errors = 0;

  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMP = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  sha256_round_ctrl dut (
    .clk(clk), .n_rst(n_rst), .start(start), .block_in(block_in), .chain_in(chain_in),
    .busy(busy), .done(done), .digest(digest), .comp_load(comp_load), .comp_init(comp_init),
    .comp_enable(comp_enable), .w_i(w_i), .k_i(k_i), .work_state(work_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  always @(posedge clk)
    work_state <= comp_load ? comp_init : comp_enable ? rnd(work_state, w_i, k_i) : work_state;

  always @(negedge clk)
    if (n_rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done digest=%h", digest);
      end else begin
        mon_exp = exp_q.pop_front();
        if (digest !== mon_exp) begin
          errors++;
          $display("FAIL digest got=%h exp=%h", digest, mon_exp);
        end
      end
    end

  task automatic start_block(input logic [511:0] blk, input logic [255:0] chn, input logic [255:0] exp_d);
    @(negedge clk);
    block_in = blk;
    chain_in = chn;
    start = 1'b1;
    exp_q.push_back(exp_d);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, comp_load, comp_enable} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, comp_load, comp_enable});
    end
    checks++;
    if ({w_i, k_i} !== 64'h0) begin
      errors++;
      $display("FAIL reset_wk got=%h exp=0", {w_i, k_i});
    end
    checks++;
    if ({digest, comp_init} !== 512'h0) begin
      errors++;
      $display("FAIL reset_digest_init got=%h exp=0", {digest, comp_init});
    end
    n_rst = 1'b1;
  endtask

  task automatic test_abc;
    int n_load = 0, n_en = 0, done_k = -1;
    start_block(ABC, IV, D_ABC);
    for (int k = 0; k < 80; k++) begin
      if (comp_load) n_load++;
      if (comp_enable) n_en++;
      if (done && done_k < 0) done_k = k;
      if (k == 0) begin
        checks++;
        if (!busy || comp_init !== IV) begin
          errors++;
          $display("FAIL load_state busy=%b init=%h exp busy=1 init=%h", busy, comp_init, IV);
        end
      end
      if (k == 1) begin
        checks++;
        if (w_i !== 32'h61626380 || k_i !== 32'h428a2f98) begin
          errors++;
          $display("FAIL t0_wk got=%h/%h exp=61626380/428a2f98", w_i, k_i);
        end
      end
      if (k == 16) begin
        checks++;
        if (w_i !== 32'h00000018) begin
          errors++;
          $display("FAIL t15_w got=%h exp=00000018", w_i);
        end
      end
      if (k == 64) begin
        checks++;
        if (k_i !== 32'hc67178f2 || !comp_enable) begin
          errors++;
          $display("FAIL t63_k got=%h en=%b exp=c67178f2 en=1", k_i, comp_enable);
        end
      end
      if (k == 65) begin
        checks++;
        if ({w_i, k_i} !== 64'h0 || !busy) begin
          errors++;
          $display("FAIL final_wk got=%h busy=%b exp=0 busy=1", {w_i, k_i}, busy);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n_load != 1 || n_en != 64) begin
      errors++;
      $display("FAIL abc_cycles load=%0d en=%0d exp=1/64", n_load, n_en);
    end
    checks++;
    if (done_k != 66) begin
      errors++;
      $display("FAIL abc_latency got=%0d exp=66", done_k);
    end
  endtask

  task automatic test_empty;
    int done_k = -1;
    start_block(EMPTY, IV, D_EMP);
    for (int k = 0; k < 90 && done_k < 0; k++) begin
      if (k == 5) begin
        block_in = {16{$urandom()}};
        chain_in = {8{$urandom()}};
      end
      if (done) done_k = k;
      else @(negedge clk);
    end
    checks++;
    if (done_k != 66) begin
      errors++;
      $display("FAIL empty_latency got=%0d exp=66", done_k);
    end
  endtask

  task automatic test_back_to_back;
    int n_done = 0, first_k = -1, second_k = -1;
    start_block(ABC, IV, D_ABC);
    for (int k = 0; k < 150; k++) begin
      if (k == 11) begin
        start = 1'b1;
        block_in = EMPTY;
        chain_in = '0;
      end
      if (k == 12) start = 1'b0;
      if (k == 65) begin
        start = 1'b1;
        block_in = {16{$urandom()}};
      end
      if (k == 66) begin
        checks++;
        if (!done || busy) begin
          errors++;
          $display("FAIL done_cycle done=%b busy=%b exp=1/0", done, busy);
        end
        block_in = EMPTY;
        chain_in = IV;
        exp_q.push_back(D_EMP);
      end
      if (k == 67) begin
        start = 1'b0;
        checks++;
        if (!busy || !comp_load) begin
          errors++;
          $display("FAIL restart busy=%b load=%b exp=1/1", busy, comp_load);
        end
      end
      if (done) begin
        n_done++;
        if (first_k < 0) first_k = k;
        else second_k = k;
      end
      @(negedge clk);
    end
    checks++;
    if (n_done != 2 || first_k != 66 || second_k != 133) begin
      errors++;
      $display("FAIL b2b_dones n=%0d k=%0d,%0d exp=2 at 66,133", n_done, first_k, second_k);
    end
  endtask

  task automatic test_reset_mid;
    int n_done = 0, done_k = -1;
    start_block(ABC, IV, D_ABC);
    repeat (31) @(negedge clk);
    checks++;
    if (k_i !== 32'h06ca6351) begin
      errors++;
      $display("FAIL t30_k got=%h exp=06ca6351", k_i);
    end
    n_rst = 1'b0;
    #1;
    void'(exp_q.pop_back());
    checks++;
    if ({busy, done, comp_load, comp_enable, w_i, k_i, digest, comp_init} !== '0) begin
      errors++;
      $display("FAIL async_reset busy=%b en=%b w=%h k=%h digest=%h", busy, comp_enable, w_i, k_i, digest);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL abort_activity got=%0d exp=0", n_done);
    end
    start_block(ABC, IV, D_ABC);
    for (int k = 0; k < 90 && done_k < 0; k++) begin
      if (done) done_k = k;
      else @(negedge clk);
    end
    checks++;
    if (done_k != 66) begin
      errors++;
      $display("FAIL restart_latency got=%0d exp=66", done_k);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, ports clk and n_rst; all other ports are listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to hash one 512-bit block; sampled only in IDLE.
REQ-005 block_in  input  512  message block, word 0 = block_in[511:480] (big-endian word order).
REQ-006 chain_in  input  256  incoming chaining value H0..H7, H0 = chain_in[255:224].
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when digest is updated.
REQ-009 digest  output  256  registered result, same word order as chain_in.
REQ-010 comp_load  output  1  loads comp_init into the compression datapath's a..h.
REQ-011 comp_init  output  256  latched chain_in, a = [255:224] ... h = [31:0].
REQ-012 comp_enable  output  1  advances the compression datapath by one round.
REQ-013 w_i  output  32  message-schedule word for the current round.
REQ-014 k_i  output  32  SHA-256 round constant for the current round.
REQ-015 work_state  input  256  datapath a..h, same packing as comp_init.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, ROUND, FINAL; start=1 in IDLE moves to LOAD at that edge and latches block_in and chain_in.
REQ-017 LOAD SHALL last one cycle with comp_load=1, comp_enable=0, then enter ROUND with round index 0.
REQ-018 ROUND SHALL last exactly 64 cycles, comp_enable=1 each cycle, 6-bit round index t = 0..63, incrementing each cycle; t=63 moves to FINAL.
REQ-019 During ROUND, k_i SHALL equal K[t] per FIPS 180-4; w_i and k_i SHALL be 0 outside ROUND.
REQ-020 w_i SHALL equal block word t for t<16; else sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32, using a 16-word sliding window.
REQ-021 sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
REQ-022 FINAL SHALL last one cycle and register digest word j = chain word j + work_state word j, mod 2^32, with no carry between words; then return to IDLE.
REQ-023 done SHALL be high in the first IDLE cycle after FINAL only; digest SHALL hold until the next FINAL.
REQ-024 Latency: start sampled at edge T -> done high in the cycle after edge T+66.
REQ-025 start while busy SHALL be ignored, with no queueing; start in the done cycle SHALL be accepted.
REQ-026 Latched block and chain SHALL not change while busy, regardless of block_in/chain_in.

Reset
REQ-027 n_rst low SHALL immediately force IDLE, t=0, busy=0, done=0, comp_load=0, comp_enable=0, w_i=0, k_i=0, digest=0, comp_init=0, window cleared.
REQ-028 Reset mid-operation SHALL abort the block with no done pulse; the first start after reset SHALL run a full 66-cycle sequence.

Structure
REQ-029 A shared package sha256_pkg SHALL hold the 64-entry K constant table, the FIPS initial hash H0 as a 256-bit constant, the FSM state enum, and sigma/rotate functions.
REQ-030 The message schedule SHALL be one sub-module sha256_msg_sched (load, advance, 512-bit block in, 32-bit w out); the controller holds FSM, counter and final adder.

Verification
REQ-031 Block "abc" (61626380 00...0 00000018), chain=H0, datapath attached -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-032 Empty-message padded block (80000000 00...0), chain=H0 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-033 "abc" run -> 1 comp_load cycle, exactly 64 comp_enable cycles; t=0: w_i=61626380, k_i=428a2f98; t=63: k_i=c67178f2; done after edge T+66.
REQ-034 start pulsed at ROUND t=10 and again in FINAL -> ignored, single done; start in the done cycle -> second run begins, busy stays high.
REQ-035 n_rst asserted at ROUND t=30 -> all outputs 0 at once, no done; restart with "abc" -> correct digest.
